// File: rtl/srec_axil_tm_pkg.sv
// Shared types and constants for the AXI4-Lite self-test master:
// FSM states, run-mode encodings and the OKAY response code.
package srec_axil_tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_WRITE_ONLY = 2'b00;
    localparam logic [1:0] MODE_READ_CMP   = 2'b01;
    localparam logic [1:0] MODE_WRITE_READ = 2'b10;
    localparam logic [1:0] MODE_READ_ONLY  = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/srec_axil_pattern_gen.sv
// Maps a word index to its target address and test pattern; one instance
// serves both the write and the read-compare paths.
module srec_axil_pattern_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                IDX_W     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       SEED      = 32'h0
) (
    input  logic [IDX_W-1:0]  idx_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int STRIDE = DATA_W / 8;

    logic [31:0] word;

    // The pattern is a 32-bit sum, zero-extended on wide buses.
    assign word   = SEED + 32'(idx_i);
    assign addr_o = BASE_ADDR + ADDR_W'(idx_i) * ADDR_W'(STRIDE);
    assign data_o = DATA_W'(word);

endmodule

// File: rtl/srec_axil_test_master.sv
// AXI4-Lite test master: writes and/or reads back a seeded incrementing
// pattern, one transfer outstanding at a time, with per-handshake timeout.
module srec_axil_test_master
    import srec_axil_tm_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_TXN          = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = C_M_AXI_ADDR_WIDTH'(32'h4000_0000),
    parameter logic [31:0]                   C_SEED             = 32'hA5A5_0000,
    parameter int                            C_TIMEOUT          = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              INIT_AXI_TXN,
    input  logic [1:0]                        MODE,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [15:0]                       ERR_COUNT,
    output logic                              BUSY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int IDX_W = $clog2(C_NUM_TXN + 1);
    localparam int TMR_W = $clog2(C_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_NUM_TXN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(C_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              init_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              issue_q, issue_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0]     awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]     wdata_q, wdata_d, exp_q, exp_d;
    logic              done_q, done_d, error_q, error_d, busy_q, busy_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic [AW-1:0]     pg_addr;
    logic [DW-1:0]     pg_data;
    logic              start, reload, word_done, fail, cmp_en;

    srec_axil_pattern_gen #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .IDX_W     (IDX_W),
        .BASE_ADDR (C_BASE_ADDR),
        .SEED      (C_SEED)
    ) u_pattern (
        .idx_i  (idx_q),
        .addr_o (pg_addr),
        .data_o (pg_data)
    );

    assign start  = INIT_AXI_TXN & ~init_q & ~busy_q;
    assign cmp_en = (mode_q == MODE_READ_CMP) || (mode_q == MODE_WRITE_READ);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        issue_d   = issue_q;
        tmr_d     = tmr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        exp_d     = exp_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        reload    = 1'b0;
        word_done = 1'b0;
        fail      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = (MODE == MODE_WRITE_ONLY || MODE == MODE_WRITE_READ) ? ST_WRITE : ST_READ;
                    mode_d    = MODE;
                    idx_d     = '0;
                    issue_d   = 1'b1;
                    tmr_d     = '0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
                end
            end
            ST_WRITE: begin
                if (issue_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = pg_addr;
                    wdata_d   = pg_data;
                    issue_d   = 1'b0;
                    reload    = 1'b1;
                end else if (bready_q) begin
                    if (M_AXI_BVALID) begin
                        bready_d  = 1'b0;
                        reload    = 1'b1;
                        word_done = 1'b1;
                        fail      = (M_AXI_BRESP != RESP_OKAY);
                    end
                end else begin
                    if (awvalid_q && M_AXI_AWREADY) begin
                        awvalid_d = 1'b0;
                        reload    = 1'b1;
                    end
                    if (wvalid_q && M_AXI_WREADY) begin
                        wvalid_d = 1'b0;
                        reload   = 1'b1;
                    end
                    if (!awvalid_d && !wvalid_d) bready_d = 1'b1;
                end
            end
            ST_READ: begin
                if (issue_q) begin
                    arvalid_d = 1'b1;
                    araddr_d  = pg_addr;
                    exp_d     = pg_data;
                    issue_d   = 1'b0;
                    reload    = 1'b1;
                end else if (arvalid_q) begin
                    if (M_AXI_ARREADY) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        reload    = 1'b1;
                    end
                end else if (rready_q && M_AXI_RVALID) begin
                    rready_d  = 1'b0;
                    reload    = 1'b1;
                    word_done = 1'b1;
                    fail      = (M_AXI_RRESP != RESP_OKAY) || (cmp_en && (M_AXI_RDATA != exp_q));
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (word_done) begin
            if (idx_q == IDX_LAST) begin
                if (state_q == ST_WRITE && mode_q == MODE_WRITE_READ) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    issue_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                issue_d = 1'b1;
            end
        end

        // Any stalled handshake ends the run with every VALID/READY dropped.
        if (state_q == ST_WRITE || state_q == ST_READ) begin
            if (reload) begin
                tmr_d = '0;
            end else if (tmr_q == TMR_LAST) begin
                fail      = 1'b1;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                issue_d   = 1'b0;
                state_d   = ST_DONE;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        if (fail) begin
            error_d   = 1'b1;
            err_cnt_d = sat_inc16(err_cnt_q);
        end

        busy_d = (state_d == ST_WRITE) || (state_d == ST_READ);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            mode_q    <= '0;
            init_q    <= 1'b0;
            idx_q     <= '0;
            issue_q   <= 1'b0;
            tmr_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            exp_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            init_q    <= INIT_AXI_TXN;
            idx_q     <= idx_d;
            issue_q   <= issue_d;
            tmr_q     <= tmr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            exp_q     <= exp_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_COUNT     = err_cnt_q;
    assign BUSY          = busy_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {(DW/8){wvalid_q}};
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_srec_axil_test_master.sv
// Directed bench: a reactive AXI4-Lite slave memory plus a table of run
// vectors and hand-written timeout, mid-run reset and busy-restart sequences.
module tb_srec_axil_test_master;

    localparam int          AW   = 32;
    localparam int          DW   = 64;
    localparam int          NT   = 4;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          txn_done, error, busy;
    logic [15:0]   err_count;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    srec_axil_test_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_NUM_TXN          (NT),
        .C_BASE_ADDR        (BASE),
        .C_SEED             (SEED),
        .C_TIMEOUT          (TO)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .INIT_AXI_TXN  (init),
        .MODE          (mode),
        .TXN_DONE      (txn_done),
        .ERROR         (error),
        .ERR_COUNT     (err_count),
        .BUSY          (busy),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // Slave configuration, written only by the stimulus process.
    bit          bp = 1'b0, stall = 1'b0, chk_en = 1'b1;
    logic [1:0]  bresp_cfg = 2'b00;
    int          zero_word = -1;

    // Handshake observations, written only at the rising edge.
    bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [31:0] cap_awaddr, cap_araddr;
    logic [63:0] cap_wdata;
    logic [31:0] wa_log[$], ra_log[$];
    logic [63:0] wd_log[$];
    int          b_count = 0, viol = 0, cyc = 0;
    bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_araddr;
    logic [63:0] p_wdata;

    // Slave state, written only at the falling edge.
    bit          aw_got, w_got, b_pend, r_pend;
    logic [63:0] mem [16];

    int tests = 0;
    int fails = 0;

    function automatic int midx(input logic [31:0] a);
        return int'((a - BASE) >> 3) & 15;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else if (chk_en) begin
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) viol++;
            if (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) viol++;
            if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) viol++;
            if ((bready && (awvalid || wvalid)) || (rready && arvalid)) viol++;
        end
        if (!rst) begin
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        end
        hs_aw = awvalid && awready;
        hs_w  = wvalid && wready;
        hs_b  = bvalid && bready;
        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        if (hs_aw) begin cap_awaddr = awaddr; wa_log.push_back(awaddr); end
        if (hs_w)  begin cap_wdata = wdata;   wd_log.push_back(wdata);  end
        if (hs_ar) begin cap_araddr = araddr; ra_log.push_back(araddr); end
        if (hs_b)  b_count++;
    end

    always @(negedge clk) begin
        if (rst) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        end else begin
            if (hs_aw) aw_got = 1;
            if (hs_w)  w_got = 1;
            if (hs_b)  b_pend = 0;
            if (hs_ar) r_pend = 1;
            if (hs_r)  r_pend = 0;
            if (aw_got && w_got && !b_pend) begin
                mem[midx(cap_awaddr)] = cap_wdata;
                b_pend = 1; aw_got = 0; w_got = 0;
            end
            // Random back-pressure, forced ready every third cycle.
            awready = !stall && !aw_got && (!bp || $urandom_range(0, 1) == 1 || cyc % 3 == 0);
            wready  = !stall && !w_got  && (!bp || $urandom_range(0, 1) == 1 || cyc % 3 == 0);
            arready = !r_pend && (!bp || $urandom_range(0, 1) == 1 || cyc % 3 == 0);
            bresp   = bresp_cfg;
            if (!b_pend) bvalid = 0;
            else if (!bvalid) bvalid = !bp || $urandom_range(0, 1) == 1 || cyc % 3 == 0;
            if (!r_pend) rvalid = 0;
            else if (!rvalid) begin
                rvalid = !bp || $urandom_range(0, 1) == 1 || cyc % 3 == 0;
                rdata  = (midx(cap_araddr) == zero_word) ? 64'h0 : mem[midx(cap_araddr)];
                rresp  = 2'b00;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_init(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (txn_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        bit         bp;
        logic [1:0] bresp;
        int         zero_word;
        bit         exp_err;
        int         exp_cnt;
        int         exp_w;
        int         exp_r;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int wb, wdb, rb, cnt;

        vecs[0] = '{2'b10, 1'b0, 2'b00, -1, 1'b0, 0, 4, 4};
        vecs[1] = '{2'b01, 1'b0, 2'b00,  2, 1'b1, 1, 0, 4};
        vecs[2] = '{2'b00, 1'b0, 2'b10, -1, 1'b1, 4, 4, 0};
        vecs[3] = '{2'b11, 1'b0, 2'b00,  2, 1'b0, 0, 0, 4};
        vecs[4] = '{2'b10, 1'b1, 2'b00, -1, 1'b0, 0, 4, 4};
        vecs[5] = '{2'b01, 1'b1, 2'b00, -1, 1'b0, 0, 0, 4};

        repeat (3) @(negedge clk);
        chk("reset status", {txn_done, error, busy, err_count}, 64'h0);
        chk("reset valid/ready", {awvalid, wvalid, bready, arvalid, rready}, 64'h0);
        chk("reset awaddr/araddr", {awaddr, araddr}, 64'h0);
        chk("reset wdata", wdata, 64'h0);
        chk("reset wstrb", 64'(wstrb), 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            bp = vecs[v].bp;
            bresp_cfg = vecs[v].bresp;
            zero_word = vecs[v].zero_word;
            wb = wa_log.size(); wdb = wd_log.size(); rb = ra_log.size();
            pulse_init(vecs[v].mode);
            wait_done(ok);
            chk($sformatf("v%0d done", v), 64'(ok), 64'h1);
            chk($sformatf("v%0d error", v), 64'(error), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d err_count", v), 64'(err_count), 64'(vecs[v].exp_cnt));
            chk($sformatf("v%0d busy", v), 64'(busy), 64'h0);
            chk($sformatf("v%0d writes", v), 64'(wa_log.size() - wb), 64'(vecs[v].exp_w));
            chk($sformatf("v%0d reads", v), 64'(ra_log.size() - rb), 64'(vecs[v].exp_r));
            for (int k = 0; k < vecs[v].exp_w && wb + k < wa_log.size() && wdb + k < wd_log.size(); k++) begin
                chk($sformatf("v%0d awaddr[%0d]", v, k), 64'(wa_log[wb + k]), 64'(BASE + 32'(8 * k)));
                chk($sformatf("v%0d wdata[%0d]", v, k), wd_log[wdb + k], {32'h0, SEED + 32'(k)});
            end
            for (int k = 0; k < vecs[v].exp_r && rb + k < ra_log.size(); k++)
                chk($sformatf("v%0d araddr[%0d]", v, k), 64'(ra_log[rb + k]), 64'(BASE + 32'(8 * k)));
            $display("[TB] vector %0d mode %b: done=%0b error=%0b err_count=%0d", v, vecs[v].mode, txn_done, error, err_count);
        end

        // Timeout: AW and W both stalled, run must end 16 cycles after AWVALID rises.
        bp = 0; bresp_cfg = 0; zero_word = -1; stall = 1; chk_en = 0;
        pulse_init(2'b00);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (awvalid) break;
        end
        chk("timeout awvalid rose", 64'(awvalid), 64'h1);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            cnt++;
            if (txn_done) break;
        end
        chk("timeout latency", 64'(cnt), 64'd16);
        chk("timeout error/count", {error, err_count}, {47'h0, 1'b1, 16'd1});
        chk("timeout valids dropped", {awvalid, wvalid, bready, busy}, 64'h0);
        $display("[TB] timeout run: latency=%0d error=%0b err_count=%0d", cnt, error, err_count);
        stall = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;

        // Reset mid-run after the second write response.
        wb = b_count;
        pulse_init(2'b00);
        for (int k = 0; k < 200; k++) begin
            if (b_count >= wb + 2) break;
            @(posedge clk); #1;
        end
        chk("midrun two writes seen", 64'(b_count - wb), 64'd2);
        chk("midrun busy before reset", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("async reset status", {txn_done, error, busy, err_count}, 64'h0);
        chk("async reset valids", {awvalid, wvalid, bready, arvalid, rready}, 64'h0);
        chk("async reset addr/data", {awaddr, wdata[31:0]}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb = wa_log.size();
        pulse_init(2'b00);
        wait_done(ok);
        chk("restart done", 64'(ok), 64'h1);
        chk("restart writes", 64'(wa_log.size() - wb), 64'd4);
        if (wa_log.size() > wb) chk("restart first awaddr", 64'(wa_log[wb]), 64'(BASE));
        $display("[TB] reset restart: done=%0b writes=%0d", txn_done, wa_log.size() - wb);

        // Second INIT pulse while busy must be ignored.
        bp = 1;
        wb = wa_log.size(); rb = ra_log.size();
        pulse_init(2'b10);
        repeat (5) @(negedge clk);
        chk("busy during run", 64'(busy), 64'h1);
        pulse_init(2'b00);
        wait_done(ok);
        chk("busy-pulse done", 64'(ok), 64'h1);
        chk("busy-pulse writes", 64'(wa_log.size() - wb), 64'd4);
        chk("busy-pulse reads", 64'(ra_log.size() - rb), 64'd4);
        chk("busy-pulse errors", {error, err_count}, 64'h0);
        if (wa_log.size() >= wb + 4)
            chk("busy-pulse last awaddr", 64'(wa_log[wb + 3]), 64'(BASE + 32'd24));
        $display("[TB] busy restart: writes=%0d reads=%0d", wa_log.size() - wb, ra_log.size() - rb);

        chk("protocol violations", 64'(viol), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/srec_axil_test_master.md
SREC_AXIL_TEST_MASTER -- requirements
Module: srec_axil_test_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, data width; legal values 32 or 64.
REQ-003 Parameter C_NUM_TXN, default 4, words per run; legal range 1..256.
REQ-004 Parameter C_BASE_ADDR, default 32'h4000_0000, first target address.
REQ-005 Parameter C_SEED, default 32'hA5A5_0000, pattern seed.
REQ-006 Parameter C_TIMEOUT, default 1024, maximum cycles any single handshake may wait.
REQ-007 ACLK  in  1  sole clock; all logic on the rising edge.
REQ-008 ARESET  in  1  asynchronous, active-high reset.
REQ-009 INIT_AXI_TXN  in  1  run request; rising edge starts a run.
REQ-010 MODE  in  2  run mode, sampled at start: 00 write-only, 01 read-compare, 10 write then read-compare, 11 read-only without compare.
REQ-011 TXN_DONE  out  1  high when the run has ended; stays high until the next start.
REQ-012 ERROR  out  1  sticky error flag for the current run.
REQ-013 ERR_COUNT  out  16  count of failed words in the current run; saturates at 16'hFFFF.
REQ-014 BUSY  out  1  high while a run is in progress.
REQ-015 M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in; widths ADDR_WIDTH/3/1/1; write address channel.
REQ-016 M_AXI_WDATA/WSTRB/WVALID out, WREADY in; widths DATA_WIDTH/DATA_WIDTH/8/1/1; write data channel.
REQ-017 M_AXI_BRESP/BVALID in, BREADY out; widths 2/1/1; write response channel.
REQ-018 M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in; widths ADDR_WIDTH/3/1/1; read address channel.
REQ-019 M_AXI_RDATA/RRESP/RVALID in, RREADY out; widths DATA_WIDTH/2/1/1; read data channel.

Function
REQ-020 A start is detected by a registered rising-edge detect on INIT_AXI_TXN; it is ignored while BUSY=1.
REQ-021 FSM states: IDLE, WRITE, READ, DONE. A start moves IDLE or DONE to WRITE for modes 00/10 and to READ for modes 01/11.
REQ-022 A start clears TXN_DONE, ERROR and ERR_COUNT and resets the word index i to 0.
REQ-023 Word i address = C_BASE_ADDR + i*(C_M_AXI_DATA_WIDTH/8).
REQ-024 Word i data = C_SEED + i, zero-extended to the data width; WSTRB all ones; AWPROT/ARPROT = 3'b000.
REQ-025 WRITE state: AWVALID and WVALID assert together in the same cycle.
REQ-026 WRITE state: each of AWVALID and WVALID drops independently on its own handshake.
REQ-027 WRITE state: BREADY asserts after both handshakes complete; the next word issues only after the B handshake; at most one write is outstanding.
REQ-028 READ state: ARVALID asserts and drops on the AR handshake, then RREADY asserts until the R handshake; at most one read is outstanding.
REQ-029 VALID signals shall not drop before their handshake, and addresses/data shall stay stable while VALID is high.
REQ-030 A word fails when BRESP≠00, RRESP≠00, or RDATA≠expected data (modes 01/10 only); each failed word sets ERROR and increments ERR_COUNT by 1.
REQ-031 After word C_NUM_TXN-1: mode 10 goes WRITE->READ with i=0; all other cases go to DONE.
REQ-032 DONE state: TXN_DONE=1 and BUSY=0.
REQ-033 A timeout counter reloads on every handshake; if it reaches C_TIMEOUT, ERROR is set, ERR_COUNT increments, all VALID/READY outputs drop the next cycle, and the FSM enters DONE.
REQ-034 The index counter is ceil(log2(C_NUM_TXN+1)) bits wide; C_NUM_TXN=1 performs exactly one transfer per phase.

Reset
REQ-035 ARESET=1 forces, asynchronously, state IDLE and all outputs 0 (TXN_DONE, ERROR, ERR_COUNT, BUSY, every VALID/READY, addresses, data).
REQ-036 Reset asserted mid-run abandons the run; the first start after release begins at i=0.

Structure
REQ-037 Package srec_axil_tm_pkg holds the FSM state enum, the MODE encodings and the RESP_OKAY constant.
REQ-038 Sub-module srec_axil_pattern_gen(i -> address, expected data) is shared by the write and read paths.

Verification
REQ-039 Mode 10, defaults, AXI VIP slave memory, zero-wait: 4 writes to 0x4000_0000..0x4000_000C with data A5A5_0000..A5A5_0003, then 4 matching reads -> TXN_DONE=1, ERROR=0, ERR_COUNT=0.
REQ-040 Mode 01 with the slave preloaded so word 2 reads 0 -> ERROR=1, ERR_COUNT=1, all 4 reads complete.
REQ-041 Mode 00, slave returns BRESP=10 on every write -> ERR_COUNT=4, ERROR=1.
REQ-042 Slave AWREADY held low, C_TIMEOUT=16 -> DONE 16 cycles after AWVALID rises, ERROR=1, AWVALID=0.
REQ-043 ARESET pulsed after the 2nd write B handshake, then INIT pulsed -> all outputs 0 during reset, and the restarted run first writes 0x4000_0000.
REQ-044 INIT pulsed while BUSY=1, random READY back-pressure, C_M_AXI_DATA_WIDTH=64 -> the second pulse is ignored, 8-byte address stride, no protocol violations.
